// File: rtl/tmw_harvester.sv
// Entropy harvester: runs an external TMW window/RO counter pair once per bit,
// collects the LSB of each RO edge count and hands out NBITS-bit words.
module tmw_harvester #(
    parameter int WIDTH = 5,
    parameter int CW    = 16,
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic [WIDTH-1:0] window_i,
    input  logic             ro_en_i,
    input  logic [CW-1:0]    ro_cnt_i,
    input  logic             ready_i,
    output logic             tmw_clr_o,
    output logic             tmw_en_o,
    output logic [WIDTH-1:0] max_counts_o,
    output logic [NBITS-1:0] data_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int BCW = $clog2(NBITS + 1);
    localparam int TCW = WIDTH + 3;
    localparam logic [TCW-1:0] TMO_LAST = {1'b0, {(WIDTH + 2){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ARM,
        S_MEASURE,
        S_SAMPLE,
        S_OUTPUT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [BCW-1:0]   bit_cnt;
    logic [TCW-1:0]   tmo_cnt;
    logic [NBITS-1:0] shift_q;
    logic [NBITS-1:0] data_q;
    logic [WIDTH-1:0] max_q;
    logic             err_q;

    logic             launch;
    logic             in_window;
    logic             tmo_hit;
    logic             last_bit;
    logic             handshake;
    logic [NBITS-1:0] shift_next;
    logic             unused_ro_hi;

    // Only the RO count parity carries entropy; the upper bits are ignored.
    assign unused_ro_hi = ^ro_cnt_i[CW-1:1];

    assign launch     = (state == S_IDLE) && (start_i || cont_i);
    assign in_window  = (state == S_ARM) || (state == S_MEASURE);
    assign tmo_hit    = in_window && (tmo_cnt == TMO_LAST);
    assign last_bit   = (bit_cnt == BCW'(NBITS - 1));
    assign handshake  = (state == S_OUTPUT) && ready_i;
    assign shift_next = {ro_cnt_i[0], shift_q[NBITS-1:1]};

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_i || cont_i) begin
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_next = S_ARM;
            end
            S_ARM: begin
                if (tmo_hit) begin
                    state_next = S_IDLE;
                end else if (ro_en_i) begin
                    state_next = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (tmo_hit) begin
                    state_next = S_IDLE;
                end else if (!ro_en_i) begin
                    state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                state_next = last_bit ? S_OUTPUT : S_CLEAR;
            end
            S_OUTPUT: begin
                if (ready_i) begin
                    state_next = cont_i ? S_CLEAR : S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        tmw_clr_o = 1'b0;
        tmw_en_o  = 1'b0;
        valid_o   = 1'b0;
        busy_o    = 1'b1;
        case (state)
            S_IDLE:    busy_o    = 1'b0;
            S_CLEAR:   tmw_clr_o = 1'b1;
            S_ARM:     tmw_en_o  = 1'b1;
            S_MEASURE: tmw_en_o  = 1'b1;
            S_OUTPUT:  valid_o   = 1'b1;
            default:   busy_o    = 1'b1;
        endcase
    end

    // NOTE: reset is synchronous; the sample shift register is cleared along
    // with everything else so a post-reset word never shows stale bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            tmo_cnt <= '0;
            shift_q <= '0;
            data_q  <= '0;
            max_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= tmo_hit;

            if (launch) begin
                max_q <= (window_i == '0) ? WIDTH'(1) : window_i;
            end

            // Timeout budget is per bit: restarted by every CLEAR.
            if (state == S_CLEAR || tmo_hit) begin
                tmo_cnt <= '0;
            end else if (in_window) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (tmo_hit || handshake) begin
                bit_cnt <= '0;
            end else if (state == S_SAMPLE) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            // Shifting in from the top leaves the first sample in bit 0 after
            // NBITS samples; an aborted word is simply overwritten next time.
            if (state == S_SAMPLE) begin
                shift_q <= shift_next;
                if (last_bit) begin
                    data_q <= shift_next;
                end
            end
        end
    end

    assign max_counts_o = max_q;
    assign data_o       = data_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_tmw_harvester.sv
// Bench for tmw_harvester: a behavioural window/RO counter responder feeds
// random entropy bits, and a bit queue predicts every delivered word.
module tb_tmw_harvester;

    localparam int WIDTH = 5;
    localparam int CW    = 16;
    localparam int NBITS = 8;

    logic             clk;
    logic             rst;
    logic             start_i;
    logic             cont_i;
    logic [WIDTH-1:0] window_i;
    logic             ro_en_i;
    logic [CW-1:0]    ro_cnt_i;
    logic             ready_i;
    logic             tmw_clr_o;
    logic             tmw_en_o;
    logic [WIDTH-1:0] max_counts_o;
    logic [NBITS-1:0] data_o;
    logic             valid_o;
    logic             busy_o;
    logic             err_o;

    int checks;
    int errors;
    int clr_seen;
    int busy_low;
    bit kill_ro;
    bit sent_q[$];
    bit forced_q[$];

    tmw_harvester #(.WIDTH(WIDTH), .CW(CW), .NBITS(NBITS)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .cont_i(cont_i),
        .window_i(window_i), .ro_en_i(ro_en_i), .ro_cnt_i(ro_cnt_i),
        .ready_i(ready_i), .tmw_clr_o(tmw_clr_o), .tmw_en_o(tmw_en_o),
        .max_counts_o(max_counts_o), .data_o(data_o), .valid_o(valid_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Window/RO counter model: clear on tmw_clr, then hold ro_en high for
    // max_counts enabled cycles. Each clear draws the next entropy bit.
    initial begin
        int wcnt;
        bit b;
        logic [CW-1:0] r;
        wcnt = 0;
        ro_en_i = 1'b0;
        ro_cnt_i = '0;
        forever begin
            @(negedge clk);
            if (tmw_clr_o) begin
                wcnt = 0;
                ro_en_i = 1'b0;
                if (forced_q.size() > 0) b = forced_q.pop_front();
                else b = 1'($urandom_range(0, 1));
                sent_q.push_back(b);
                r = CW'($urandom);
                r[0] = b;
                ro_cnt_i = r;
            end else if (kill_ro) begin
                ro_en_i = 1'b0;
            end else if (tmw_en_o) begin
                if (wcnt < int'(max_counts_o)) begin
                    ro_en_i = 1'b1;
                    wcnt++;
                end else begin
                    ro_en_i = 1'b0;
                end
            end
        end
    end

    task automatic model_word(output logic [NBITS-1:0] w);
        for (int i = 0; i < NBITS; i++) begin
            if (sent_q.size() > 0) w[i] = sent_q.pop_front();
            else w[i] = 1'bx;
        end
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic handshake();
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    // Counts clears and busy drops from the current cycle until valid_o.
    task automatic wait_valid(input int limit);
        int n;
        n = 0;
        while (!valid_o && n < limit) begin
            if (tmw_clr_o) clr_seen++;
            if (!busy_o) busy_low++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (!valid_o) begin
            errors++;
            $display("FAIL wait_valid: valid_o=%b after %0d cycles, expected 1", valid_o, n);
        end
    endtask

    task automatic expect_all_zero(input string tag);
        checks++;
        if ({tmw_clr_o, tmw_en_o, valid_o, busy_o, err_o} !== 5'b0) begin
            errors++;
            $display("FAIL %s_flags: clr/en/valid/busy/err=%b, expected 00000", tag,
                     {tmw_clr_o, tmw_en_o, valid_o, busy_o, err_o});
        end
        checks++;
        if (data_o !== '0) begin
            errors++;
            $display("FAIL %s_data: data_o=%h, expected 00", tag, data_o);
        end
        checks++;
        if (max_counts_o !== '0) begin
            errors++;
            $display("FAIL %s_max: max_counts_o=%0d, expected 0", tag, max_counts_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        expect_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy_o=%b, expected 0", busy_o);
        end
    endtask

    task automatic test_single_word();
        sent_q.delete();
        forced_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        window_i = 5'd4;
        ready_i = 1'b0;
        clr_seen = 0;
        do_start();
        checks++;
        if (max_counts_o !== 5'd4) begin
            errors++;
            $display("FAIL single_max: max_counts_o=%0d, expected 4", max_counts_o);
        end
        wait_valid(400);
        checks++;
        if (data_o !== 8'h4D) begin
            errors++;
            $display("FAIL single_data: data_o=%h, expected 4d", data_o);
        end
        checks++;
        if (clr_seen != NBITS) begin
            errors++;
            $display("FAIL single_clr: clears=%0d, expected %0d", clr_seen, NBITS);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h4D) begin
            errors++;
            $display("FAIL single_hold: valid_o=%b data_o=%h, expected 1/4d", valid_o, data_o);
        end
        handshake();
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || data_o !== 8'h4D) begin
            errors++;
            $display("FAIL single_after: valid=%b busy=%b data=%h, expected 0/0/4d",
                     valid_o, busy_o, data_o);
        end
        sent_q.delete();
    endtask

    task automatic test_backpressure();
        logic [NBITS-1:0] exp;
        sent_q.delete();
        window_i = WIDTH'($urandom_range(1, 8));
        ready_i = 1'b0;
        clr_seen = 0;
        do_start();
        wait_valid(400);
        model_word(exp);
        checks++;
        if (data_o !== exp) begin
            errors++;
            $display("FAIL bp_data: data_o=%h, expected %h", data_o, exp);
        end
        clr_seen = 0;
        for (int i = 0; i < 20; i++) begin
            start_i = (i % 4 == 1);
            @(negedge clk);
            if (tmw_clr_o) clr_seen++;
            checks++;
            if (valid_o !== 1'b1 || data_o !== exp) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid_o=%b data_o=%h, expected 1/%h",
                         i, valid_o, data_o, exp);
            end
        end
        start_i = 1'b0;
        checks++;
        if (clr_seen != 0) begin
            errors++;
            $display("FAIL bp_clr: clears=%0d during backpressure, expected 0", clr_seen);
        end
        handshake();
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: busy=%b valid=%b, expected 0/0", busy_o, valid_o);
        end
    endtask

    task automatic test_continuous();
        logic [NBITS-1:0] exp;
        sent_q.delete();
        window_i = WIDTH'($urandom_range(1, 10));
        ready_i = 1'b1;
        cont_i = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            clr_seen = 0;
            busy_low = 0;
            wait_valid(400);
            model_word(exp);
            checks++;
            if (data_o !== exp) begin
                errors++;
                $display("FAIL cont_data[%0d]: data_o=%h, expected %h", w, data_o, exp);
            end
            checks++;
            if (clr_seen != NBITS) begin
                errors++;
                $display("FAIL cont_clr[%0d]: clears=%0d, expected %0d", w, clr_seen, NBITS);
            end
            checks++;
            if (busy_low != 0) begin
                errors++;
                $display("FAIL cont_busy[%0d]: busy low %0d cycles, expected 0", w, busy_low);
            end
            if (w == 2) cont_i = 1'b0;
            @(negedge clk);
        end
        ready_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL cont_stop: busy_o=%b, expected 0", busy_o);
        end
    endtask

    task automatic test_zero_window();
        logic [NBITS-1:0] exp;
        sent_q.delete();
        window_i = '0;
        ready_i = 1'b1;
        do_start();
        checks++;
        if (max_counts_o !== 5'd1) begin
            errors++;
            $display("FAIL zero_max: max_counts_o=%0d, expected 1", max_counts_o);
        end
        wait_valid(400);
        model_word(exp);
        checks++;
        if (data_o !== exp) begin
            errors++;
            $display("FAIL zero_data: data_o=%h, expected %h", data_o, exp);
        end
        @(negedge clk);
        ready_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: busy_o=%b, expected 0", busy_o);
        end
    endtask

    task automatic test_timeout();
        int t;
        int err_at;
        int err_pulses;
        bit seen_valid;
        t = -1;
        err_at = -1;
        err_pulses = 0;
        seen_valid = 1'b0;
        kill_ro = 1'b1;
        window_i = 5'd4;
        do_start();
        for (int i = 0; i < 300; i++) begin
            if (t < 0 && tmw_en_o) t = 0;
            else if (t >= 0) t++;
            if (valid_o) seen_valid = 1'b1;
            if (err_o) begin
                err_pulses++;
                err_at = t;
            end
            @(negedge clk);
        end
        checks++;
        if (err_at != 128) begin
            errors++;
            $display("FAIL tmo_time: err_o at %0d cycles after ARM, expected 128", err_at);
        end
        checks++;
        if (err_pulses != 1) begin
            errors++;
            $display("FAIL tmo_pulses: err_o high %0d cycles, expected 1", err_pulses);
        end
        checks++;
        if (seen_valid || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_idle: valid seen=%b busy=%b, expected 0/0", seen_valid, busy_o);
        end
        kill_ro = 1'b0;
        sent_q.delete();
    endtask

    task automatic test_midword_reset();
        logic [NBITS-1:0] exp;
        int n;
        sent_q.delete();
        window_i = WIDTH'($urandom_range(1, 6));
        do_start();
        clr_seen = 0;
        n = 0;
        while (n < 400) begin
            if (tmw_clr_o) clr_seen++;
            if (clr_seen == 4) break;
            @(negedge clk);
            n++;
        end
        checks++;
        if (clr_seen != 4) begin
            errors++;
            $display("FAIL mid_progress: clears=%0d, expected 4", clr_seen);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_all_zero("mid_reset");
        @(negedge clk);
        sent_q.delete();
        clr_seen = 0;
        ready_i = 1'b0;
        do_start();
        wait_valid(400);
        model_word(exp);
        checks++;
        if (data_o !== exp || clr_seen != NBITS) begin
            errors++;
            $display("FAIL mid_word: data_o=%h clears=%0d, expected %h/%0d",
                     data_o, clr_seen, exp, NBITS);
        end
        handshake();
    endtask

    task automatic test_random_words();
        logic [NBITS-1:0] exp;
        logic [WIDTH-1:0] win;
        for (int k = 0; k < 6; k++) begin
            sent_q.delete();
            win = WIDTH'($urandom_range(0, 31));
            window_i = win;
            ready_i = 1'b0;
            do_start();
            window_i = ~win;
            checks++;
            if (max_counts_o !== ((win == 0) ? WIDTH'(1) : win)) begin
                errors++;
                $display("FAIL rnd_max[%0d]: max_counts_o=%0d, window was %0d", k, max_counts_o, win);
            end
            wait_valid(600);
            model_word(exp);
            checks++;
            if (data_o !== exp) begin
                errors++;
                $display("FAIL rnd_data[%0d]: data_o=%h, expected %h", k, data_o, exp);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            handshake();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        kill_ro = 1'b0;
        rst = 1'b1;
        start_i = 1'b0;
        cont_i = 1'b0;
        window_i = '0;
        ready_i = 1'b0;
        test_reset();
        test_single_word();
        test_backpressure();
        test_continuous();
        test_zero_window();
        test_timeout();
        test_midword_reset();
        test_random_words();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
